pipelined_rca_adder: RTL and testbench

//  Parametrised pipelined ripple-carry adder. WIDTH is split into STAGE_BITS slices.
//  The carry between slices is registered, one slice per clock.

---
 rtl/pipelined_rca_adder.sv | 113 +++++++++++
 tb/tb_pipelined_rca_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: one STAGE_BITS slice per stage, with registered inter-slice carry.
// Operands ride along the pipe (skew) and low sum bits pass forward (deskew), so one add is accepted per cycle.
module pipelined_rca_adder #(
  parameter int WIDTH      = 16,
  parameter int STAGE_BITS = 4
) (
  input  logic             clk,
  input  logic             Rs,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SB      = (STAGE_BITS >= 1) ? STAGE_BITS : 1;
  localparam int NSTAGES = (WIDTH / SB >= 1) ? WIDTH / SB : 1;

  generate
    if (STAGE_BITS < 1 || (WIDTH % SB) != 0) begin : g_param_check
      $error("pipelined_rca_adder: WIDTH must be a multiple of STAGE_BITS and STAGE_BITS >= 1");
    end
  endgenerate

  // Returns {overflow, carry_out, sum}; overflow = carry into slice MSB ^ carry out of it.
  function automatic logic [SB+1:0] add_slice(input logic [SB-1:0] a,
                                               input logic [SB-1:0] b,
                                               input logic          c);
    logic [SB:0] t;
    logic        c_msb;
    t     = {1'b0, a} + {1'b0, b} + {{SB{1'b0}}, c};
    c_msb = t[SB-1] ^ a[SB-1] ^ b[SB-1];
    return {c_msb ^ t[SB], t};
  endfunction

  logic             vld_p [NSTAGES];
  logic             cy_p  [NSTAGES];
  logic             ov_p  [NSTAGES];
  logic [WIDTH-1:0] sum_p [NSTAGES];
  logic [WIDTH-1:0] a_p   [NSTAGES];
  logic [WIDTH-1:0] b_p   [NSTAGES];

  logic             vld_n [NSTAGES];
  logic             cy_n  [NSTAGES];
  logic             ov_n  [NSTAGES];
  logic [WIDTH-1:0] sum_n [NSTAGES];
  logic [WIDTH-1:0] a_n   [NSTAGES];
  logic [WIDTH-1:0] b_n   [NSTAGES];
  logic [SB+1:0]    res   [NSTAGES];

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    // Stage 0: slice 0 of the incoming operands with Cin
    res[0]            = add_slice(A[SB-1:0], B[SB-1:0], Cin);
    vld_n[0]          = in_valid;
    cy_n[0]           = res[0][SB];
    ov_n[0]           = res[0][SB+1];
    sum_n[0]          = '0;
    sum_n[0][SB-1:0]  = res[0][SB-1:0];
    a_n[0]            = A;
    b_n[0]            = B;
    // Stage s: slice s from the skewed operands and the previous registered carry
    for (int s = 1; s < NSTAGES; s++) begin
      res[s]                = add_slice(a_p[s-1][s*SB +: SB], b_p[s-1][s*SB +: SB], cy_p[s-1]);
      vld_n[s]              = vld_p[s-1];
      cy_n[s]               = res[s][SB];
      ov_n[s]               = res[s][SB+1];
      sum_n[s]              = sum_p[s-1];
      sum_n[s][s*SB +: SB]  = res[s][SB-1:0];
      a_n[s]                = a_p[s-1];
      b_n[s]                = b_p[s-1];
    end
  end

  // All stages shift together on advance; a stalled output freezes the whole pipe
  always_ff @(posedge clk) begin
    if (Rs) begin
      for (int s = 0; s < NSTAGES; s++) begin
        vld_p[s] <= 1'b0;
        cy_p[s]  <= 1'b0;
        ov_p[s]  <= 1'b0;
        sum_p[s] <= '0;
        a_p[s]   <= '0;
        b_p[s]   <= '0;
      end
    end else if (advance) begin
      for (int s = 0; s < NSTAGES; s++) begin
        vld_p[s] <= vld_n[s];
        cy_p[s]  <= cy_n[s];
        ov_p[s]  <= ov_n[s];
        sum_p[s] <= sum_n[s];
        a_p[s]   <= a_n[s];
        b_p[s]   <= b_n[s];
      end
    end
  end

  // Output register is the last stage
  assign out_valid = vld_p[NSTAGES-1];
  assign Sum       = sum_p[NSTAGES-1];
  assign Carry     = cy_p[NSTAGES-1];
  assign Overflow  = ov_p[NSTAGES-1];

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed and scoreboarded checks for pipelined_rca_adder (16/4 pipeline and 8/8 single-stage variant).
module tb_pipelined_rca_adder;

  logic        clk = 1'b0;
  logic        Rs, in_valid, out_ready, Cin;
  logic [15:0] A, B;
  logic        in_ready, out_valid, Carry, Overflow;
  logic [15:0] Sum;

  logic        in_valid8, out_ready8, cin8;
  logic [7:0]  a8, b8;
  logic        in_ready8, out_valid8, carry8, ovf8;
  logic [7:0]  sum8;

  int errors = 0;
  int checks = 0;

  logic [15:0] va [6];
  logic [15:0] vb [6];
  logic [15:0] vs [6];
  logic [17:0] q [$];

  always #5 clk = ~clk;

  pipelined_rca_adder #(.WIDTH(16), .STAGE_BITS(4)) dut (
    .clk(clk), .Rs(Rs), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Carry(Carry), .Overflow(Overflow));

  pipelined_rca_adder #(.WIDTH(8), .STAGE_BITS(8)) dut8 (
    .clk(clk), .Rs(Rs), .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8), .Cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .Sum(sum8), .Carry(carry8), .Overflow(ovf8));

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    Rs = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
    cyc(); cyc();
    Rs = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (Sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h want=0000", Sum); end
    checks++; if ({Carry, Overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b want=00", Carry, Overflow); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8 got=%b want=0", out_valid8); end
  endtask

  task automatic test_carry_chain();
    A = 16'hFFFF; B = 16'h0001; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chain_early got=%b want=0", out_valid); end
    cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL chain_valid got=%b want=1", out_valid); end
    checks++; if ({Carry, Overflow, Sum} !== {2'b10, 16'h0000})
      begin errors++; $display("FAIL chain_result got=c%b v%b %h want=c1 v0 0000", Carry, Overflow, Sum); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chain_dup got=%b want=0", out_valid); end
  endtask

  task automatic test_overflow();
    A = 16'h7FFF; B = 16'h0000; Cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    A = 16'h8000; B = 16'h8000; Cin = 1'b0;
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    checks++; if ({out_valid, Carry, Overflow, Sum} !== {3'b101, 16'h8000})
      begin errors++; $display("FAIL ovf_pos got=o%b c%b v%b %h want=o1 c0 v1 8000", out_valid, Carry, Overflow, Sum); end
    cyc();
    checks++; if ({out_valid, Carry, Overflow, Sum} !== {3'b111, 16'h0000})
      begin errors++; $display("FAIL ovf_neg got=o%b c%b v%b %h want=o1 c1 v1 0000", out_valid, Carry, Overflow, Sum); end
    cyc();
  endtask

  task automatic test_back_to_back();
    va[0] = 16'h0001; vb[0] = 16'h0002; vs[0] = 16'h0003;
    va[1] = 16'h00FF; vb[1] = 16'h0001; vs[1] = 16'h0100;
    va[2] = 16'h1234; vb[2] = 16'h4321; vs[2] = 16'h5555;
    va[3] = 16'hF0F0; vb[3] = 16'h0F10; vs[3] = 16'h0000;
    out_ready = 1'b1; Cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A = va[i]; B = vb[i]; in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({out_valid, Carry, Sum} !== {1'b1, (i == 3), vs[i]})
        begin errors++; $display("FAIL b2b_%0d got=o%b c%b %h want=o1 c%0d %h", i, out_valid, Carry, Sum, (i == 3), vs[i]); end
      cyc();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got=%b want=0", out_valid); end
  endtask

  task automatic test_stall();
    int in_i = 0, out_i = 0, stall_left = 3;
    bit stall_on = 1'b0;
    for (int i = 0; i < 6; i++) begin
      va[i] = 16'h0101 * i; vb[i] = 16'h0010 + i;
    end
    vs[0] = 16'h0010; vs[1] = 16'h0112; vs[2] = 16'h0214;
    vs[3] = 16'h0316; vs[4] = 16'h0418; vs[5] = 16'h051A;
    Cin = 1'b0;
    for (int c = 0; c < 40 && out_i < 6; c++) begin
      in_valid = (in_i < 6);
      A = va[in_i % 6]; B = vb[in_i % 6];
      if (out_valid && !stall_on) stall_on = 1'b1;
      out_ready = !(stall_on && stall_left > 0);
      #1;
      if (!out_ready) begin
        stall_left--;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
        checks++; if (Sum !== vs[out_i]) begin errors++; $display("FAIL stall_hold got=%h want=%h", Sum, vs[out_i]); end
      end
      if (out_valid && out_ready) begin
        checks++; if (Sum !== vs[out_i]) begin errors++; $display("FAIL stall_order_%0d got=%h want=%h", out_i, Sum, vs[out_i]); end
        out_i++;
      end
      if (in_valid && in_ready) in_i++;
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_i != 6) begin errors++; $display("FAIL stall_count got=%0d want=6", out_i); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_dup got=%b want=0", out_valid); end
      cyc();
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1; Cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 16'h1111 * (i + 1); B = 16'h0001; in_valid = 1'b1;
      cyc();
    end
    Rs = 1'b1; A = 16'h2222; B = 16'h2222;
    cyc();
    Rs = 1'b0; in_valid = 1'b0; #1;
    checks++; if ({out_valid, Sum} !== {1'b0, 16'h0000})
      begin errors++; $display("FAIL flush_now got=o%b %h want=o0 0000", out_valid, Sum); end
    for (int c = 0; c < 5; c++) begin
      cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle_%0d got=%b want=0", c, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [16:0] full;
    logic        v;
    q.delete();
    for (int c = 0; c < 10200; c++) begin
      if (c < 10000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rand_extra got=%h want=none", Sum); end
        else if ({Overflow, Carry, Sum} !== q[0])
          begin errors++; $display("FAIL rand_result got=%h want=%h", {Overflow, Carry, Sum}, q[0]); end
        if (out_ready && q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        full = {1'b0, A} + {1'b0, B} + {16'h0000, Cin};
        v    = (A[15] == B[15]) && (full[15] != A[15]);
        q.push_back({v, full});
      end
      cyc();
      if (c >= 10000 && q.size() == 0 && !out_valid) break;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain got=%0d want=0", q.size()); end
    in_valid = 1'b0;
  endtask

  task automatic test_latency1();
    a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1; #1;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL lat1_idle got=%b want=0", out_valid8); end
    cyc();
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    checks++; if ({out_valid8, carry8, ovf8, sum8} !== {3'b110, 8'h2D})
      begin errors++; $display("FAIL lat1_first got=o%b c%b v%b %h want=o1 c1 v0 2d", out_valid8, carry8, ovf8, sum8); end
    cyc();
    in_valid8 = 1'b0;
    checks++; if ({out_valid8, carry8, ovf8, sum8} !== {3'b101, 8'h80})
      begin errors++; $display("FAIL lat1_second got=o%b c%b v%b %h want=o1 c0 v1 80", out_valid8, carry8, ovf8, sum8); end
    cyc();
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL lat1_tail got=%b want=0", out_valid8); end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
